// File: rtl/chmux_pkg.sv
// Shared types and helpers for the channel_mux_rr selector.
package chmux_pkg;

    typedef enum logic {MODE_DIRECT = 1'b0, MODE_RR = 1'b1} chmux_mode_t;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} chmux_st_t;

    // Successor of idx in a ring of n entries.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requester at or above ptr, wrapping modulo NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 3,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = en;
                gnt_idx  = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/channel_mux_rr.sv
// N-channel selector (direct select or round-robin) with a one-deep registered
// valid/ready output. Define CHMUX_PARITY_EN to add the out_par output.
module channel_mux_rr
    import chmux_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 6,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [NUM_CH*IN_W-1:0] in_data,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   sel_err
`ifdef CHMUX_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    chmux_st_t                   st, st_nxt;
    logic [NUM_CH-1:0][IN_W-1:0] ch_data;
    logic [SEL_W-1:0]            rr_ptr;
    logic                        mode_rr, sel_ok, can_load, xfer;
    logic [NUM_CH-1:0]           dir_rdy, arb_gnt;
    logic [SEL_W-1:0]            arb_idx, xfer_idx;
    logic                        arb_any;

    assign ch_data  = in_data;
    assign mode_rr  = (chmux_mode_t'(mode) == MODE_RR);
    assign sel_ok   = (int'(sel) < NUM_CH);
    assign can_load = (st == ST_EMPTY) || out_ready;

    // Out-of-range sel matches no channel, so it naturally yields no ready.
    always_comb begin
        dir_rdy = '0;
        for (int k = 0; k < NUM_CH; k++)
            dir_rdy[k] = can_load && (int'(sel) == k);
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .en      (can_load && mode_rr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign in_ready = rst ? '0 : (mode_rr ? arb_gnt : dir_rdy);
    assign xfer     = mode_rr ? (arb_any && can_load) : |(in_valid & dir_rdy);
    assign xfer_idx = mode_rr ? arb_idx : sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_EMPTY;
        else     st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_EMPTY: if (xfer) st_nxt = ST_FULL;
            ST_FULL:  if (out_ready) st_nxt = xfer ? ST_FULL : ST_EMPTY;
            default:  st_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (st == ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
            sel_err  <= 1'b0;
        end else begin
            sel_err <= !mode_rr && !sel_ok;
            if (xfer) begin
                out_data <= OUT_W'(ch_data[xfer_idx]);
                out_ch   <= xfer_idx;
                if (mode_rr) rr_ptr <= SEL_W'(next_idx(int'(arb_idx), NUM_CH));
            end
        end
    end

`ifdef CHMUX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       out_par <= 1'b0;
        else if (xfer) out_par <= ^ch_data[xfer_idx];
    end
`endif

endmodule

// File: tb/tb_channel_mux_rr.sv
// Self-checking bench for channel_mux_rr (NUM_CH=3, IN_W=4, OUT_W=6).
module tb_channel_mux_rr;

    localparam int NCH = 3;
    localparam int IW  = 4;
    localparam int OW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [NCH*IW-1:0] in_data = '0;
    logic [NCH-1:0] in_valid = '0;
    logic [NCH-1:0] in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_ch;
    logic          sel_err;
`ifdef CHMUX_PARITY_EN
    logic          out_par;
`endif

    int vecs = 0;
    int errs = 0;

    // Reference state: what the consumer should see and where RR search starts.
    logic          m_full;
    logic [OW-1:0] m_data;
    int            m_ch, m_ptr;
    logic          m_err, m_par;

    channel_mux_rr #(.NUM_CH(NCH), .IN_W(IW), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .sel_err(sel_err)
`ifdef CHMUX_PARITY_EN
        , .out_par(out_par)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] chd(input int k);
        return in_data[k*IW +: IW];
    endfunction

    function automatic logic [NCH-1:0] model_ready();
        logic [NCH-1:0] r;
        r = '0;
        if (rst || (m_full && !out_ready)) return r;
        if (mode == 1'b0) begin
            if (int'(sel) < NCH) r[sel] = 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (r == '0 && in_valid[(m_ptr + i) % NCH]) r[(m_ptr + i) % NCH] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_err = 0; m_par = 0;
    endtask

    task automatic model_advance();
        logic [NCH-1:0] r;
        int k;
        bit can_load;
        r = model_ready() & in_valid;
        can_load = !m_full || out_ready;
        k = -1;
        for (int i = 0; i < NCH; i++) if (r[i]) k = i;
        if (can_load) begin
            if (k >= 0) begin
                m_full = 1; m_data = OW'(chd(k)); m_ch = k; m_par = ^chd(k);
                if (mode) m_ptr = (k + 1) % NCH;
            end else m_full = 0;
        end
        m_err = (mode == 1'b0) && (int'(sel) >= NCH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_data(input logic [IW-1:0] d0, d1, d2);
        in_data = {d2, d1, d0};
    endtask

    task automatic test_reset();
        rst = 1; in_valid = '1; mode = 1; out_ready = 1;
        model_reset();
        @(posedge clk); #1;
        vecs++; if (in_ready !== 3'b000) begin errs++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
        vecs++; if ({out_valid, sel_err, out_ch, out_data} !== 10'd0) begin errs++;
            $display("FAIL reset_outputs got v=%b e=%b ch=%0d d=%h exp all 0", out_valid, sel_err, out_ch, out_data); end
        rst = 0; in_valid = '0;
        tick();
    endtask

    task automatic test_direct();
        mode = 0; sel = 2'd1; set_data(4'h5, 4'hA, 4'h6); in_valid = 3'b010; out_ready = 1;
        #1;
        vecs++; if (in_ready !== 3'b010) begin errs++; $display("FAIL direct_ready got=%b exp=010", in_ready); end
        tick();
        vecs++; if ({out_valid, out_ch, out_data} !== {1'b1, 2'd1, 6'h0A}) begin errs++;
            $display("FAIL direct_out got v=%b ch=%0d d=%h exp v=1 ch=1 d=0a", out_valid, out_ch, out_data); end
    endtask

    task automatic test_rr_wrap();
        logic [OW-1:0] exp_d [4] = '{6'd1, 6'd2, 6'd3, 6'd1};
        mode = 1; set_data(4'd1, 4'd2, 4'd3); in_valid = 3'b111; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++; if (out_data !== exp_d[i] || out_ch !== 2'((i) % 3) || !out_valid) begin errs++;
                $display("FAIL rr_wrap[%0d] got d=%h ch=%0d v=%b exp d=%h ch=%0d", i, out_data, out_ch, out_valid, exp_d[i], i % 3); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (in_ready !== 3'b000 || out_data !== 6'd1 || out_ch !== 2'd0 || !out_valid) begin errs++;
                $display("FAIL hold[%0d] got rdy=%b d=%h ch=%0d v=%b exp rdy=000 d=01 ch=0 v=1", i, in_ready, out_data, out_ch, out_valid); end
        end
        out_ready = 1; #1;
        vecs++; if (in_ready !== 3'b010) begin errs++; $display("FAIL release_ready got=%b exp=010", in_ready); end
        tick();
        vecs++; if (out_data !== 6'd2 || out_ch !== 2'd1) begin errs++;
            $display("FAIL release_out got d=%h ch=%0d exp d=02 ch=1", out_data, out_ch); end
    endtask

    task automatic test_sel_err();
        mode = 0; sel = 2'd3; in_valid = 3'b111; out_ready = 1; #1;
        vecs++; if (in_ready !== 3'b000) begin errs++; $display("FAIL bad_sel_ready got=%b exp=000", in_ready); end
        tick();
        vecs++; if (sel_err !== 1'b1 || out_valid !== 1'b0) begin errs++;
            $display("FAIL bad_sel got err=%b v=%b exp err=1 v=0", sel_err, out_valid); end
        sel = 2'd0;
        tick();
        vecs++; if (sel_err !== 1'b0 || out_valid !== 1'b1 || out_data !== 6'd1) begin errs++;
            $display("FAIL sel_recover got err=%b v=%b d=%h exp err=0 v=1 d=01", sel_err, out_valid, out_data); end
    endtask

    task automatic test_reset_mid();
        mode = 1; set_data(4'h4, 4'h7, 4'h5); in_valid = 3'b100; out_ready = 1;
        tick();
        in_valid = 3'b011;
        tick();
        #2 rst = 1; #1;
        model_reset();
        vecs++; if ({out_valid, out_ch, out_data} !== 9'd0 || in_ready !== 3'b000) begin errs++;
            $display("FAIL async_rst got v=%b ch=%0d d=%h rdy=%b exp all 0", out_valid, out_ch, out_data, in_ready); end
        rst = 0; in_valid = 3'b111; #1;
        vecs++; if (in_ready !== 3'b001) begin errs++; $display("FAIL ptr_after_rst got rdy=%b exp=001", in_ready); end
        in_valid = 3'b100;
        tick();
        vecs++; if (out_ch !== 2'd2 || out_data !== 6'h05 || !out_valid) begin errs++;
            $display("FAIL first_after_rst got ch=%0d d=%h v=%b exp ch=2 d=05 v=1", out_ch, out_data, out_valid); end
        in_valid = 3'b111; #1;
        vecs++; if (in_ready !== 3'b001) begin errs++; $display("FAIL ptr_wrap_after_ch2 got rdy=%b exp=001", in_ready); end
    endtask

`ifdef CHMUX_PARITY_EN
    task automatic test_parity();
        mode = 0; sel = 0; in_valid = 3'b001; out_ready = 1;
        set_data(4'b0111, 4'h0, 4'h0); tick();
        vecs++; if (out_par !== 1'b1) begin errs++; $display("FAIL parity_0111 got=%b exp=1", out_par); end
        set_data(4'b0011, 4'h0, 4'h0); tick();
        vecs++; if (out_par !== 1'b0) begin errs++; $display("FAIL parity_0011 got=%b exp=0", out_par); end
    endtask
`endif

    task automatic test_random();
        logic [NCH-1:0] er;
        for (int n = 0; n < 500; n++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 3'($urandom);
            in_data   = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = model_ready();
            vecs++; if (in_ready !== er) begin errs++;
                $display("FAIL rand_ready[%0d] got=%b exp=%b", n, in_ready, er); end
            tick();
            vecs++; if (out_valid !== m_full || out_data !== m_data || int'(out_ch) != m_ch || sel_err !== m_err) begin errs++;
                $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d e=%b exp v=%b d=%h ch=%0d e=%b",
                         n, out_valid, out_data, out_ch, sel_err, m_full, m_data, m_ch, m_err); end
`ifdef CHMUX_PARITY_EN
            vecs++; if (out_par !== m_par) begin errs++; $display("FAIL rand_par[%0d] got=%b exp=%b", n, out_par, m_par); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_rr_wrap();
        test_backpressure();
        test_sel_err();
        test_reset_mid();
`ifdef CHMUX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
